// File: rtl/ex_muldiv_seq.sv
// ============================================================================
// ex_muldiv_seq : multi-cycle unsigned MULTU/DIVU sequencer beside the EX ALU
// Revision      : 1.0
// ============================================================================
`default_nettype none

module ex_muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    state_t               state_q;
    logic [CNT_W-1:0]     count_q;
    logic [WIDTH-1:0]     opb_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 dbz_q;

    // acc holds {partial product, multiplier} for MULTU, {remainder, quotient} for DIVU
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   acc_mul_d;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH+1:0]     w_div_diff;
    logic                 w_borrow;
    logic [2*WIDTH-1:0]   acc_div_d;

    always_comb begin
        w_mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        acc_mul_d   = {w_mul_sum, acc_q[WIDTH-1:1]};
        w_div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        w_div_diff  = {1'b0, w_div_shift} - {2'b00, opb_q};
        w_borrow    = w_div_diff[WIDTH+1];
        acc_div_d   = {(w_borrow ? w_div_shift[WIDTH-1:0] : w_div_diff[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], ~w_borrow};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !flush) begin
                        count_q <= '0;
                        dbz_q   <= 1'b0;
                        if (!op) begin
                            opb_q   <= rs_data;
                            acc_q   <= {{WIDTH{1'b0}}, rt_data};
                            state_q <= S_MUL;
                        end else if (rt_data != '0) begin
                            opb_q   <= rt_data;
                            acc_q   <= {{WIDTH{1'b0}}, rs_data};
                            state_q <= S_DIV;
                        end else begin
                            hi_q    <= rs_data;
                            lo_q    <= '1;
                            dbz_q   <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                        count_q <= '0;
                    end else begin
                        acc_q <= acc_mul_d;
                        if (count_q == C_LAST) begin
                            hi_q    <= acc_mul_d[2*WIDTH-1:WIDTH];
                            lo_q    <= acc_mul_d[WIDTH-1:0];
                            state_q <= S_DONE;
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                end
                S_DIV: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                        count_q <= '0;
                    end else begin
                        acc_q <= acc_div_d;
                        if (count_q == C_LAST) begin
                            hi_q    <= acc_div_d[2*WIDTH-1:WIDTH];
                            lo_q    <= acc_div_d[WIDTH-1:0];
                            state_q <= S_DONE;
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    // Result is already committed; a start here is re-presented by ID/EX
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign stall       = ((state_q == S_IDLE) && start && !flush) ||
                         (state_q == S_MUL) || (state_q == S_DIV);
    assign done        = (state_q == S_DONE);
    assign div_by_zero = dbz_q;
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;

endmodule

`default_nettype wire
